alu_seq: RTL

Parametrised, registered successor of the 4-bit combinational ALU. It keeps the eight legacy operations, now WIDTH bits wide, and adds iterative one-bit-per-cycle shift/rotate operations. Results and flags are held in registers, and a start/busy/done handshake sequences each operation. The stored carry flag can be fed back as carry-in, so multi-word arithmetic chains without external glue. It sits between the register file and the write-back path of the teaching datapath.

---
 rtl/alu_seq_if.sv | 28 ++
 rtl/alu_seq.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/alu_seq_if.sv
// Request/result bundle between the register file side and alu_seq.
// The master drives operands and start; the slave returns registered result, flags and handshake.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             use_cf;
  logic [WIDTH-1:0] r;
  logic             z;
  logic             c;
  logic             s;
  logic             busy;
  logic             done;

  modport master (
    output start, op, a, b, cin, use_cf,
    input  r, z, c, s, busy, done
  );

  modport slave (
    input  start, op, a, b, cin, use_cf,
    output r, z, c, s, busy, done
  );
endinterface

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU: single-cycle arithmetic/logic plus iterative one-bit-per-cycle
// shift/rotate, with a start/busy/done handshake and stored carry usable as carry-in.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     reset,
  alu_seq_if.slave bus
);
  localparam int            SW      = $clog2(WIDTH);
  localparam logic [SW-1:0] CNT_ONE = SW'(1);

  typedef enum logic       {IDLE = 1'b0, SHIFT = 1'b1} state_e;
  typedef enum logic [1:0] {SH_SHL = 2'd0, SH_SHR = 2'd1, SH_SAR = 2'd2, SH_ROL = 2'd3} shop_e;

  state_e           state_q, state_d;
  shop_e            shop_q, shop_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic             wc_q, wc_d;
  logic [WIDTH-1:0] r_q;
  logic             z_q, c_q, s_q, done_q;

  logic             ci;
  logic [WIDTH:0]   ci_ext, one_ext, sum;
  logic [WIDTH-1:0] alu_r;
  logic             alu_c;
  logic [WIDTH-1:0] step_r;
  logic             step_c;
  logic             commit;
  logic [WIDTH-1:0] commit_r;
  logic             commit_c;

  // Single-cycle datapath; c_q here is the flag as registered before this edge.
  always_comb begin
    ci      = bus.use_cf ? c_q : bus.cin;
    ci_ext  = {{WIDTH{1'b0}}, ci};
    one_ext = {{WIDTH{1'b0}}, 1'b1};
    sum     = '0;
    alu_r   = ~bus.a;
    alu_c   = 1'b0;
    case (bus.op)
      4'b0000: sum = {1'b0, bus.a} + ci_ext;
      4'b0001: sum = {1'b0, ~bus.a} + one_ext + ci_ext;
      4'b0010: sum = {1'b0, bus.a} + {1'b0, bus.b} + ci_ext;
      4'b0011: sum = {1'b0, bus.a} + one_ext + ci_ext;
      4'b0100: alu_r = bus.a & bus.b;
      4'b0101: alu_r = bus.a | bus.b;
      4'b0110: alu_r = bus.a ^ bus.b;
      default: alu_r = ~bus.a;
    endcase
    if (bus.op[3:2] == 2'b00) begin
      alu_r = sum[WIDTH-1:0];
      alu_c = sum[WIDTH];
    end
  end

  always_comb begin
    step_r = work_q;
    step_c = 1'b0;
    case (shop_q)
      SH_SHL: begin step_r = {work_q[WIDTH-2:0], 1'b0};           step_c = work_q[WIDTH-1]; end
      SH_SHR: begin step_r = {1'b0, work_q[WIDTH-1:1]};           step_c = work_q[0];       end
      SH_SAR: begin step_r = {work_q[WIDTH-1], work_q[WIDTH-1:1]}; step_c = work_q[0];      end
      SH_ROL: begin step_r = {work_q[WIDTH-2:0], work_q[WIDTH-1]}; step_c = work_q[WIDTH-1]; end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    shop_d   = shop_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    wc_d     = wc_q;
    commit   = 1'b0;
    commit_r = alu_r;
    commit_c = alu_c;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.op[3:2] == 2'b10) begin
            state_d = SHIFT;
            shop_d  = shop_e'(bus.op[1:0]);
            cnt_d   = bus.b[SW-1:0];
            work_d  = bus.a;
            wc_d    = 1'b0;
          end else begin
            commit = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          work_d = step_r;
          wc_d   = step_c;
          cnt_d  = cnt_q - CNT_ONE;
        end else begin
          // A zero-count shift lands here directly, so wc_q is still the cleared carry.
          commit   = 1'b1;
          commit_r = work_q;
          commit_c = wc_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shop_q  <= SH_SHL;
      cnt_q   <= '0;
      work_q  <= '0;
      wc_q    <= 1'b0;
      r_q     <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      s_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shop_q  <= shop_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      wc_q    <= wc_d;
      done_q  <= commit;
      if (commit) begin
        r_q <= commit_r;
        c_q <= commit_c;
        z_q <= (commit_r == '0);
        s_q <= commit_r[WIDTH-1];
      end
    end
  end

  assign bus.r    = r_q;
  assign bus.z    = z_q;
  assign bus.c    = c_q;
  assign bus.s    = s_q;
  assign bus.busy = (state_q == SHIFT);
  assign bus.done = done_q;
endmodule
